// File: rtl/graph_isa_pkg.sv
// Shared definitions for the slice-scatter engine: state encoding,
// SCATTER command field widths and the latched command payload.
package graph_isa_pkg;

    localparam int unsigned SC_ADDR_W = 16;
    localparam int unsigned SC_LEN_W  = 16;
    localparam int unsigned SC_DATA_W = 8;
    localparam int unsigned SC_PAD_W  = 8;

    typedef enum logic [1:0] {
        SC_IDLE  = 2'd0,
        SC_RUN   = 2'd1,
        SC_DRAIN = 2'd2,
        SC_DONE  = 2'd3
    } sc_state_t;

    typedef struct packed {
        logic [SC_ADDR_W-1:0] src_base;
        logic [SC_ADDR_W-1:0] dst_base;
        logic [SC_LEN_W-1:0]  src_row_len;
        logic [SC_LEN_W-1:0]  dst_row_len;
        logic [SC_LEN_W-1:0]  dst_offset;
        logic [SC_LEN_W-1:0]  num_rows;
    } sc_cmd_t;

    // Slice window must fit inside the destination row (17-bit compare).
    function automatic logic sc_reject(input sc_cmd_t c);
        return ({1'b0, c.dst_offset} + {1'b0, c.src_row_len}) > {1'b0, c.dst_row_len};
    endfunction

endpackage

// File: rtl/slice_scatter_engine.sv
// Slice-scatter engine: copies a packed source tile into a window of each
// destination row, one byte per cycle, read and write overlapped.
// Optional macro SCATTER_PAD_EN: walk whole destination rows and fill the
// bytes outside the window with the command's pad value.
module slice_scatter_engine
    import graph_isa_pkg::*;
#(
    parameter int unsigned SRAM0_AW = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    input  logic [SC_ADDR_W-1:0]  cmd_src_base,
    input  logic [SC_ADDR_W-1:0]  cmd_dst_base,
    input  logic [SC_LEN_W-1:0]   cmd_src_row_len,
    input  logic [SC_LEN_W-1:0]   cmd_dst_row_len,
    input  logic [SC_LEN_W-1:0]   cmd_dst_offset,
    input  logic [SC_LEN_W-1:0]   cmd_num_rows,
    input  logic [SC_PAD_W-1:0]   cmd_pad_value,
    output logic                  sram_rd_en,
    output logic [SRAM0_AW-1:0]   sram_rd_addr,
    input  logic [SC_DATA_W-1:0]  sram_rd_data,
    output logic                  sram_wr_en,
    output logic [SRAM0_AW-1:0]   sram_wr_addr,
    output logic [SC_DATA_W-1:0]  sram_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    sc_state_t            state_q, state_d;
    sc_cmd_t              cmd_in, cmd_q;
    logic [SC_LEN_W-1:0]  b_q, b_d, row_q, row_d;
    logic [SRAM0_AW-1:0]  src_row_q, src_row_d, dst_row_q, dst_row_d;
    logic [SC_LEN_W-1:0]  iter_len, off_eff, srl_eff;
    logic                 accept, reject, empty, last;
    logic                 issue_d, in_win, err_d, busy_d, done_d;
    logic [SRAM0_AW-1:0]  rd_raw, wr_raw;
    logic                 rd_en_d, rd_en_q;
    logic [SRAM0_AW-1:0]  rd_addr_d, rd_addr_q;
    logic                 s0_valid_q, s0_pad_d, s0_pad_q;
    logic [SRAM0_AW-1:0]  s0_wr_addr_d, s0_wr_addr_q;
    logic                 wr_en_q, wr_pad_q;
    logic [SRAM0_AW-1:0]  wr_addr_q;
    logic                 busy_q, done_q, err_q;
    logic                 unused_sig;

    assign cmd_in = '{src_base:    cmd_src_base,
                      dst_base:    cmd_dst_base,
                      src_row_len: cmd_src_row_len,
                      dst_row_len: cmd_dst_row_len,
                      dst_offset:  cmd_dst_offset,
                      num_rows:    cmd_num_rows};

    // In IDLE the live command drives the first element; afterwards the latched copy.
    assign off_eff = (state_q == SC_IDLE) ? cmd_in.dst_offset  : cmd_q.dst_offset;
    assign srl_eff = (state_q == SC_IDLE) ? cmd_in.src_row_len : cmd_q.src_row_len;
`ifdef SCATTER_PAD_EN
    assign iter_len = (state_q == SC_IDLE) ? cmd_in.dst_row_len : cmd_q.dst_row_len;
`else
    assign iter_len = srl_eff;
`endif

    assign accept = (state_q == SC_IDLE) && cmd_valid;
    assign reject = sc_reject(cmd_in);
    assign empty  = (cmd_in.num_rows == '0) || (iter_len == '0);
    assign last   = (b_q == iter_len - SC_LEN_W'(1)) &&
                    (row_q == cmd_q.num_rows - SC_LEN_W'(1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SC_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SC_IDLE:  if (cmd_valid) state_d = (reject || empty) ? SC_DONE : SC_RUN;
            SC_RUN:   if (last) state_d = SC_DRAIN;
            SC_DRAIN: state_d = SC_DONE;
            SC_DONE:  state_d = SC_IDLE;
            default:  state_d = SC_IDLE;
        endcase
    end

    // Element walker and output next values.
    always_comb begin
        b_d       = b_q;
        row_d     = row_q;
        src_row_d = src_row_q;
        dst_row_d = dst_row_q;
        issue_d   = 1'b0;
        err_d     = 1'b0;
        if (accept) begin
            err_d = reject;
            if (!reject && !empty) begin
                issue_d   = 1'b1;
                b_d       = '0;
                row_d     = '0;
                src_row_d = SRAM0_AW'(cmd_src_base);
                dst_row_d = SRAM0_AW'(cmd_dst_base);
            end
        end else if (state_q == SC_RUN && !last) begin
            issue_d = 1'b1;
            if (b_q == iter_len - SC_LEN_W'(1)) begin
                b_d       = '0;
                row_d     = row_q + SC_LEN_W'(1);
                src_row_d = src_row_q + SRAM0_AW'(cmd_q.src_row_len);
                dst_row_d = dst_row_q + SRAM0_AW'(cmd_q.dst_row_len);
            end else begin
                b_d = b_q + SC_LEN_W'(1);
            end
        end
`ifdef SCATTER_PAD_EN
        in_win = ({1'b0, b_d} >= {1'b0, off_eff}) &&
                 ({1'b0, b_d} < ({1'b0, off_eff} + {1'b0, srl_eff}));
        rd_raw = src_row_d + SRAM0_AW'(b_d - off_eff);
        wr_raw = dst_row_d + SRAM0_AW'(b_d);
`else
        in_win = 1'b1;
        rd_raw = src_row_d + SRAM0_AW'(b_d);
        wr_raw = dst_row_d + SRAM0_AW'(off_eff) + SRAM0_AW'(b_d);
`endif
        rd_en_d      = issue_d && in_win;
        rd_addr_d    = rd_en_d ? rd_raw : '0;
        s0_wr_addr_d = issue_d ? wr_raw : '0;
        s0_pad_d     = issue_d && !in_win;
        busy_d       = (state_d != SC_IDLE);
        done_d       = (state_d == SC_DONE);
    end

    // Command latch, walker counters and the read->write pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q        <= '0;
            b_q          <= '0;
            row_q        <= '0;
            src_row_q    <= '0;
            dst_row_q    <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            s0_valid_q   <= 1'b0;
            s0_pad_q     <= 1'b0;
            s0_wr_addr_q <= '0;
            wr_en_q      <= 1'b0;
            wr_pad_q     <= 1'b0;
            wr_addr_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (accept) cmd_q <= cmd_in;
            b_q          <= b_d;
            row_q        <= row_d;
            src_row_q    <= src_row_d;
            dst_row_q    <= dst_row_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            s0_valid_q   <= issue_d;
            s0_pad_q     <= s0_pad_d;
            s0_wr_addr_q <= s0_wr_addr_d;
            wr_en_q      <= s0_valid_q;
            wr_pad_q     <= s0_pad_q;
            wr_addr_q    <= s0_wr_addr_q;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

`ifdef SCATTER_PAD_EN
    logic [SC_PAD_W-1:0] pad_q;

    // Pad byte captured with the command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pad_q <= '0;
        else if (accept) pad_q <= cmd_pad_value;
    end

    assign sram_wr_data = !wr_en_q ? '0 : (wr_pad_q ? pad_q : sram_rd_data);
    assign unused_sig   = ^{cmd_q.src_base, cmd_q.dst_base};
`else
    assign sram_wr_data = wr_en_q ? sram_rd_data : '0;
    assign unused_sig   = ^{cmd_q.src_base, cmd_q.dst_base, cmd_pad_value, wr_pad_q};
`endif

    assign sram_rd_en   = rd_en_q;
    assign sram_rd_addr = rd_addr_q;
    assign sram_wr_en   = wr_en_q;
    assign sram_wr_addr = wr_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_slice_scatter_engine.sv
// Directed bench for slice_scatter_engine with a byte-wide SRAM model and a
// scoreboard of expected writes. Honours SCATTER_PAD_EN when defined.
module tb_slice_scatter_engine;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

`ifdef SCATTER_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [15:0] cmd_src_base, cmd_dst_base, cmd_src_row_len, cmd_dst_row_len;
    logic [15:0] cmd_dst_offset, cmd_num_rows;
    logic [7:0]  cmd_pad_value;
    logic        sram_rd_en, sram_wr_en, busy, done, err;
    logic [15:0] sram_rd_addr, sram_wr_addr;
    logic [7:0]  sram_rd_data = 8'h00;
    logic [7:0]  sram_wr_data;

    logic [7:0]  mem [0:65535];
    wr_t         exp_q[$];
    wr_t         mon_e;
    int          cyc = 0;
    int          total = 0, bad = 0;
    int          rd_cnt, wr_cnt, both_cnt, done_cnt, done_cyc;
    logic        done_err;

    always #5 clk = ~clk;

    slice_scatter_engine #(.SRAM0_AW(16)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid),
        .cmd_src_base(cmd_src_base), .cmd_dst_base(cmd_dst_base),
        .cmd_src_row_len(cmd_src_row_len), .cmd_dst_row_len(cmd_dst_row_len),
        .cmd_dst_offset(cmd_dst_offset), .cmd_num_rows(cmd_num_rows),
        .cmd_pad_value(cmd_pad_value),
        .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
        .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
        .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle counter and SRAM model: read data one cycle after rd_en.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];
        if (sram_wr_en) mem[sram_wr_addr] <= sram_wr_data;
    end

    // Output monitor, sampled just after the rising edge.
    always @(posedge clk) begin
        #1;
        if (sram_rd_en) rd_cnt++;
        if (sram_rd_en && sram_wr_en) both_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = err;
        end
        if (sram_wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", {16'h0, sram_wr_addr}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", {16'h0, sram_wr_addr}, {16'h0, mon_e.addr});
                chk("wr_data", {24'h0, sram_wr_data}, {24'h0, mon_e.data});
            end
        end
    end

    task automatic issue(input logic [15:0] src, input logic [15:0] dst,
                         input logic [15:0] srl, input logic [15:0] drl,
                         input logic [15:0] off, input logic [15:0] rows,
                         input logic [7:0] pad, output int t0);
        int  il;
        wr_t e;
        @(negedge clk);
        rd_cnt = 0; wr_cnt = 0; both_cnt = 0; done_cnt = 0; done_cyc = -1; done_err = 1'bx;
        if (int'(off) + int'(srl) <= int'(drl)) begin
            il = PAD ? int'(drl) : int'(srl);
            for (int r = 0; r < int'(rows); r++) begin
                for (int b = 0; b < il; b++) begin
                    if (PAD) begin
                        e.addr = 16'(int'(dst) + r * int'(drl) + b);
                        if (b >= int'(off) && b < int'(off) + int'(srl))
                            e.data = mem[16'(int'(src) + r * int'(srl) + b - int'(off))];
                        else
                            e.data = pad;
                    end else begin
                        e.addr = 16'(int'(dst) + r * int'(drl) + int'(off) + b);
                        e.data = mem[16'(int'(src) + r * int'(srl) + b)];
                    end
                    exp_q.push_back(e);
                end
            end
        end
        cmd_src_base = src; cmd_dst_base = dst; cmd_src_row_len = srl;
        cmd_dst_row_len = drl; cmd_dst_offset = off; cmd_num_rows = rows;
        cmd_pad_value = pad; cmd_valid = 1'b1;
        t0 = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int t0, input int lat, input logic e);
        int n = 0;
        while (done_cnt == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == 0) begin
            chk({tag, " done_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, " latency"}, 32'(done_cyc - t0), 32'(lat));
            chk({tag, " err"}, {31'h0, done_err}, {31'h0, e});
        end
        repeat (3) @(negedge clk);
        chk({tag, " exp_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, " busy_idle"}, {31'h0, busy}, 32'd0);
    endtask

    initial begin
        int t0;
        rst_n = 1'b0; cmd_valid = 1'b0;
        cmd_src_base = '0; cmd_dst_base = '0; cmd_src_row_len = '0; cmd_dst_row_len = '0;
        cmd_dst_offset = '0; cmd_num_rows = '0; cmd_pad_value = '0;
        rd_cnt = 0; wr_cnt = 0; both_cnt = 0; done_cnt = 0; done_cyc = -1; done_err = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] <= 8'h55;
        for (int i = 0; i < 12; i++) mem[16'h0100 + i] <= 8'(i);
        for (int i = 0; i < 4; i++) mem[16'h0300 + i] <= 8'(8'hA0 + i);
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst ctl", {27'h0, busy, done, err, sram_rd_en, sram_wr_en}, 32'd0);
        chk("rst rd_addr", {16'h0, sram_rd_addr}, 32'd0);
        chk("rst wr_addr", {16'h0, sram_wr_addr}, 32'd0);
        chk("rst wr_data", {24'h0, sram_wr_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic scatter, with a stray command while busy that must be ignored
        issue(16'h0100, 16'h0200, 16'd4, 16'd8, 16'd2, 16'd3, 8'hEE, t0);
        cmd_src_base = 16'h4000; cmd_dst_base = 16'h0200; cmd_num_rows = 16'd9;
        cmd_dst_offset = 16'd0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done("scatter", t0, PAD ? 26 : 14, 1'b0);
        chk("scatter reads", 32'(rd_cnt), 32'd12);
        chk("scatter writes", 32'(wr_cnt), PAD ? 32'd24 : 32'd12);
        chk("scatter rd_wr_overlap", 32'(both_cnt), PAD ? 32'd12 : 32'd11);
        chk("mem 202", {24'h0, mem[16'h0202]}, 32'h00);
        chk("mem 205", {24'h0, mem[16'h0205]}, 32'h03);
        chk("mem 20A", {24'h0, mem[16'h020A]}, 32'h04);
        chk("mem 20D", {24'h0, mem[16'h020D]}, 32'h07);
        chk("mem 212", {24'h0, mem[16'h0212]}, 32'h08);
        chk("mem 215", {24'h0, mem[16'h0215]}, 32'h0B);
        chk("mem 201 outside", {24'h0, mem[16'h0201]}, PAD ? 32'hEE : 32'h55);
        chk("mem 216 outside", {24'h0, mem[16'h0216]}, PAD ? 32'hEE : 32'h55);

        // Window overruns row: rejected
        issue(16'h0100, 16'h0400, 16'd4, 16'd8, 16'd6, 16'd3, 8'hEE, t0);
        wait_done("reject", t0, 1, 1'b1);
        chk("reject sram", 32'(rd_cnt + wr_cnt), 32'd0);

        // Window exactly touching the row end is accepted
        issue(16'h0100, 16'h0500, 16'd4, 16'd8, 16'd4, 16'd1, 8'h3C, t0);
        wait_done("edge_fit", t0, PAD ? 10 : 6, 1'b0);
        chk("edge_fit writes", 32'(wr_cnt), PAD ? 32'd8 : 32'd4);
        chk("mem 507", {24'h0, mem[16'h0507]}, 32'h03);

        // Zero rows: empty
        issue(16'h0100, 16'h0400, 16'd4, 16'd8, 16'd2, 16'd0, 8'hEE, t0);
        wait_done("rows0", t0, 1, 1'b0);
        chk("rows0 sram", 32'(rd_cnt + wr_cnt), 32'd0);

        // Zero-width slice: empty, or all-pad rows in the pad build
        issue(16'h0100, 16'h0800, 16'd0, 16'd8, 16'd0, 16'd2, 8'h77, t0);
        wait_done("srl0", t0, PAD ? 18 : 1, 1'b0);
        chk("srl0 reads", 32'(rd_cnt), 32'd0);
        chk("srl0 writes", 32'(wr_cnt), PAD ? 32'd16 : 32'd0);

        // Destination address wrap
        issue(16'h0300, 16'hFFFE, 16'd4, 16'd4, 16'd0, 16'd1, 8'hEE, t0);
        wait_done("wrap", t0, 6, 1'b0);
        chk("mem FFFF", {24'h0, mem[16'hFFFF]}, 32'hA1);
        chk("mem 0001", {24'h0, mem[16'h0001]}, 32'hA3);

        // Reset mid-command
        issue(16'h0100, 16'h0200, 16'd4, 16'd8, 16'd2, 16'd3, 8'hEE, t0);
        while (cyc < t0 + 5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst ctl", {27'h0, busy, done, err, sram_rd_en, sram_wr_en}, 32'd0);
        chk("midrst addrs", {sram_rd_addr, sram_wr_addr}, 32'd0);
        chk("midrst wr_data", {24'h0, sram_wr_data}, 32'd0);
        chk("midrst wr_le4", {31'h0, (wr_cnt <= 4)}, 32'd1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("midrst no_done", 32'(done_cnt), 32'd0);
        chk("midrst no_writes", {31'h0, (wr_cnt <= 4)}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean command after reset
        issue(16'h0100, 16'h0900, 16'd4, 16'd6, 16'd1, 16'd2, 8'hEE, t0);
        wait_done("post_rst", t0, PAD ? 14 : 10, 1'b0);
        chk("mem 901", {24'h0, mem[16'h0901]}, 32'h00);
        chk("mem 90A", {24'h0, mem[16'h090A]}, 32'h07);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slice_scatter_engine.md
SLICE_SCATTER_ENGINE -- requirements
Module: slice_scatter_engine

Interface
REQ-001 SHALL have parameter: SRAM0_AW, default 16, SRAM0 address width.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command strobe, sampled only in SC_IDLE.
- cmd_src_base  in  16  packed source base.
- cmd_dst_base  in  16  destination tensor base.
- cmd_src_row_len  in  16  bytes per packed source row (slice width).
- cmd_dst_row_len  in  16  bytes per destination row.
- cmd_dst_offset  in  16  byte offset of the slice inside each destination row.
- cmd_num_rows  in  16  row count.
- cmd_pad_value  in  8  fill byte; used only with SCATTER_PAD_EN.
- sram_rd_en / sram_rd_addr / sram_rd_data  out 1 / out SRAM0_AW / in 8  SRAM0 read port; data valid 1 cycle after rd_en.
- sram_wr_en / sram_wr_addr / sram_wr_data  out 1 / out SRAM0_AW / out 8  SRAM0 write port.
- busy  out  1  high whenever state != SC_IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  high with done when the command was rejected.

Function
REQ-003 SHALL implement the inverse of slice: for row r in 0..num_rows-1 and byte b in 0..src_row_len-1, copy src_base + r*src_row_len + b to dst_base + r*dst_row_len + dst_offset + b.
REQ-004 SHALL use states SC_IDLE, SC_RUN, SC_DRAIN, SC_DONE: IDLE->RUN on cmd_valid; RUN->DRAIN after the last read; DRAIN->DONE; DONE->IDLE.
REQ-005 SHALL latch all cmd_* fields on the accept cycle; cmd_valid outside SC_IDLE SHALL be ignored.
REQ-006 SHALL reject the command on accept if dst_offset + src_row_len > dst_row_len (17-bit compare): go IDLE->DONE, no SRAM access, done=1 and err=1 for one cycle.
REQ-007 SHALL treat num_rows==0 or src_row_len==0 (non-pad build) as an empty command: IDLE->DONE, no SRAM access, done=1, err=0.
REQ-008 SHALL be pipelined: in SC_RUN exactly one read per cycle with no bubbles at row boundaries; each read's write SHALL occur exactly one cycle later with sram_wr_data = sram_rd_data.
REQ-009 SHALL advance addresses with running row pointers (src_ptr += src_row_len, dst_ptr += dst_row_len); no multiplier.
REQ-010 SHALL compute all addresses modulo 2^SRAM0_AW (silent wrap).
REQ-011 Latency, accept at cycle T0, N = num_rows*src_row_len: reads T1..TN, writes T2..TN+1 (TN+1 = SC_DRAIN), done at TN+2.
REQ-012 SHALL NOT detect overlap between source and destination regions; data in overlapping bytes is unspecified.
REQ-013 SHALL assert sram_rd_en and sram_wr_en in the same cycle when pipelined; both ports are independent.

Reset
REQ-014 On rst_n low, state SHALL be SC_IDLE, all pipeline valids and registers 0, and busy, done, err, sram_rd_en and sram_wr_en all 0; addr and data outputs SHALL be 0.
REQ-015 Reset mid-command SHALL abort immediately. Any pending pipelined write SHALL be dropped, and no done pulse SHALL be produced.

Configuration
REQ-016 Macro SCATTER_PAD_EN, when defined:
- each row iterates over all dst_row_len bytes.
- bytes outside [dst_offset, dst_offset+src_row_len) SHALL be written with cmd_pad_value and no read.
- in-window bytes SHALL follow REQ-008.
- a pad flag SHALL travel in the pipeline stage, so write timing is unchanged.
- N becomes num_rows*dst_row_len.
- the empty condition becomes num_rows==0 or dst_row_len==0.
REQ-017 When SCATTER_PAD_EN is undefined, cmd_pad_value SHALL be ignored and bytes outside the window SHALL be untouched.

Structure
REQ-018 The sc_state_t enum and the SCATTER command field widths SHALL live in graph_isa_pkg.
REQ-019 SHALL be a single module with no sub-module; counters and pointers are inline. Expected size is about 200 lines.

Verification
REQ-020 Scenario: src_base=0x100, src_row_len=4, dst_base=0x200, dst_row_len=8, dst_offset=2, rows=3, src bytes 0..11. Required: dst 0x202..0x205=0..3, 0x20A..0x20D=4..7, 0x212..0x215=8..11; 12 writes; done at T14.
REQ-021 Scenario: dst_offset=6, src_row_len=4, dst_row_len=8. Required: err=1 and done=1 at T1; zero reads and writes.
REQ-022 Scenario: rows=0. Required: done=1, err=0 at T1; no SRAM activity.
REQ-023 Scenario: SCATTER_PAD_EN build, same command as REQ-020, pad=0xEE. Required: all 24 dst bytes written, non-window bytes=0xEE, done at T26.
REQ-024 Scenario: dst_base=0xFFFE, dst_row_len=4, rows=1, offset 0, src_row_len=4. Required: writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-025 Scenario: assert rst_n low at T5 of the REQ-020 run. Required: at most 4 writes completed, all outputs 0, and a new command is accepted cleanly after reset.
